// File: rtl/fp16_special_sched.sv
// fp16_special_sched: round-robin scheduler sharing one FP16 special-value
// classifier among NREQ requesters. Each requester owns a one-entry response
// slot; at most one operand is in flight in the classifier at a time per tag.
// Optional statistics counters are built when FP16_SPECIAL_SCHED_STATS_EN is
// defined; otherwise the stat_* outputs are tied to zero.
module fp16_special_sched #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sched_en,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [16*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [5*NREQ-1:0]   rsp_flags,
   output logic [16*NREQ-1:0]  rsp_data,
   output logic                cls_enable,
   output logic                cls_valid,
   output logic                cls_sign,
   output logic [4:0]          cls_exp,
   output logic [9:0]          cls_mant,
   input  logic                cls_s_valid,
   input  logic                cls_is_nan,
   input  logic                cls_is_pinf,
   input  logic                cls_is_ninf,
   input  logic                cls_is_normal,
   input  logic                cls_is_subnormal,
   input  logic                cls_sign_out,
   input  logic [4:0]          cls_exp_out,
   input  logic [9:0]          cls_mant_out,
   output logic                busy,
   output logic                err,
   input  logic                stat_clr,
   output logic [CNT_W-1:0]    stat_nan_cnt,
   output logic [CNT_W-1:0]    stat_inf_cnt,
   output logic [CNT_W-1:0]    stat_sub_cnt
);

   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [TW-1:0]   rr_ptr;
   logic [TW-1:0]   tag;
   logic            inflight;
   logic            armed;
   logic [NREQ-1:0] eligible;
   logic            issue;
   logic [TW-1:0]   grant_idx;
   logic [TW-1:0]   scan_idx;
   logic [15:0]     grant_data;
   logic            slot_wr;
   logic            inflight_nxt;
   logic [NREQ-1:0] rsp_valid_nxt;

   // Requester may issue only when its slot is empty and none of its operands is in flight
   always_comb begin
      eligible = req_valid & ~rsp_valid;
      if (inflight) eligible[tag] = 1'b0;
   end

   // Round-robin search upward from rr_ptr; reset also blocks issue
   always_comb begin
      issue     = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      if (sched_en && rst_n) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = TW'((32'(rr_ptr) + k) % NREQ);
            if (!issue && eligible[scan_idx]) begin
               issue     = 1'b1;
               grant_idx = scan_idx;
            end
         end
      end
      grant_data = req_data[16*grant_idx +: 16];
   end

   // Drive the classifier and the one-hot grant in the issue cycle
   always_comb begin
      cls_enable = issue;
      cls_valid  = issue;
      {cls_sign, cls_exp, cls_mant} = issue ? grant_data : '0;
      req_ready = '0;
      if (issue) req_ready[grant_idx] = 1'b1;
   end

   // Next-state for the tag register and slot valid bits
   always_comb begin
      slot_wr       = cls_s_valid && inflight;
      inflight_nxt  = issue || (inflight && !cls_s_valid);
      rsp_valid_nxt = rsp_valid & ~rsp_ready;
      if (slot_wr) rsp_valid_nxt[tag] = 1'b1;
   end

   // Control state: pointer, in-flight tag, slot valids, busy and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         tag       <= '0;
         inflight  <= 1'b0;
         armed     <= 1'b0;
         err       <= 1'b0;
         rsp_valid <= '0;
         busy      <= 1'b0;
      end else begin
         armed     <= 1'b1;
         inflight  <= inflight_nxt;
         rsp_valid <= rsp_valid_nxt;
         busy      <= inflight_nxt || (|rsp_valid_nxt);
         if (issue) begin
            tag    <= grant_idx;
            rr_ptr <= (grant_idx == TW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         end
         // The classifier is not reset, so a stale result in the first cycle is ignored
         if (cls_s_valid && !inflight && armed) err <= 1'b1;
      end
   end

   // Capture the classifier result into the issuing requester's slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_flags <= '0;
         rsp_data  <= '0;
      end else if (slot_wr) begin
         rsp_flags[5*tag +: 5] <= {cls_is_nan, cls_is_pinf, cls_is_ninf,
                                   cls_is_normal, cls_is_subnormal};
         rsp_data[16*tag +: 16] <= {cls_sign_out, cls_exp_out, cls_mant_out};
      end
   end

`ifdef FP16_SPECIAL_SCHED_STATS_EN
   // Saturating class counters; clear wins over a coincident increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_nan_cnt <= '0;
         stat_inf_cnt <= '0;
         stat_sub_cnt <= '0;
      end else if (stat_clr) begin
         stat_nan_cnt <= '0;
         stat_inf_cnt <= '0;
         stat_sub_cnt <= '0;
      end else if (slot_wr) begin
         if (cls_is_nan && (stat_nan_cnt != '1))
            stat_nan_cnt <= stat_nan_cnt + 1'b1;
         if ((cls_is_pinf || cls_is_ninf) && (stat_inf_cnt != '1))
            stat_inf_cnt <= stat_inf_cnt + 1'b1;
         if (cls_is_subnormal && (stat_sub_cnt != '1))
            stat_sub_cnt <= stat_sub_cnt + 1'b1;
      end
   end
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_nan_cnt    = '0;
   assign stat_inf_cnt    = '0;
   assign stat_sub_cnt    = '0;
`endif

endmodule

// File: tb/tb_fp16_special_sched.sv
// Testbench for fp16_special_sched: behavioural classifier on the cls_* side,
// scoreboard of expected per-requester responses, per-cycle monitor.
module tb_fp16_special_sched;
   localparam int N  = 4;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sched_en = 1'b0;
   logic stat_clr = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [16*N-1:0] req_data = '0;
   logic [N-1:0]    rsp_ready = '0;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [5*N-1:0]  rsp_flags;
   logic [16*N-1:0] rsp_data;
   logic cls_enable, cls_valid, cls_sign;
   logic [4:0] cls_exp;
   logic [9:0] cls_mant;
   logic cls_s_valid, cls_is_nan, cls_is_pinf, cls_is_ninf, cls_is_normal, cls_is_subnormal;
   logic cls_sign_out;
   logic [4:0] cls_exp_out;
   logic [9:0] cls_mant_out;
   logic busy, err;
   logic [CW-1:0] stat_nan_cnt, stat_inf_cnt, stat_sub_cnt;

   fp16_special_sched #(.NREQ(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flags(rsp_flags), .rsp_data(rsp_data),
      .cls_enable(cls_enable), .cls_valid(cls_valid), .cls_sign(cls_sign),
      .cls_exp(cls_exp), .cls_mant(cls_mant), .cls_s_valid(cls_s_valid),
      .cls_is_nan(cls_is_nan), .cls_is_pinf(cls_is_pinf), .cls_is_ninf(cls_is_ninf),
      .cls_is_normal(cls_is_normal), .cls_is_subnormal(cls_is_subnormal),
      .cls_sign_out(cls_sign_out), .cls_exp_out(cls_exp_out), .cls_mant_out(cls_mant_out),
      .busy(busy), .err(err), .stat_clr(stat_clr),
      .stat_nan_cnt(stat_nan_cnt), .stat_inf_cnt(stat_inf_cnt), .stat_sub_cnt(stat_sub_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // FP16 class from the number-format rules: {nan, +inf, -inf, normal, subnormal}
   function automatic logic [4:0] classify(input logic [15:0] v);
      if (v[14:10] == 5'h1F) begin
         if (v[9:0] != 0) return 5'b10000;
         return v[15] ? 5'b00100 : 5'b01000;
      end
      if (v[14:10] == 5'h00) return (v[9:0] != 0) ? 5'b00001 : 5'b00000;
      return 5'b00010;
   endfunction

   function automatic logic [15:0] rand_op();
      case ($urandom_range(0, 11))
         0: return 16'h7C00;
         1: return 16'hFC00;
         2: return 16'h7E00;
         3: return 16'hFC01;
         4: return 16'h0000;
         5: return 16'h8000;
         6: return 16'h0001;
         7: return 16'h83FF;
         8: return 16'h3C00;
         9: return 16'h7BFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Behavioural classifier: one-cycle registered result, not reset
   logic        c_sv = 1'b0;
   logic        spur = 1'b0;
   logic [4:0]  c_f = '0;
   logic [15:0] c_d = '0;
   always @(posedge clk) begin
      c_sv <= cls_valid;
      c_f  <= classify({cls_sign, cls_exp, cls_mant});
      c_d  <= {cls_sign, cls_exp, cls_mant};
   end
   assign cls_s_valid = c_sv | spur;
   assign {cls_is_nan, cls_is_pinf, cls_is_ninf, cls_is_normal, cls_is_subnormal} = c_f;
   assign {cls_sign_out, cls_exp_out, cls_mant_out} = c_d;

   // Reference model state
   typedef struct packed {
      logic [4:0]  f;
      logic [15:0] d;
      logic [31:0] rdy;
   } item_t;
   item_t q [N][$];
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] taken = '0;
   int m_rr = 0;
   int m_nan = 0, m_inf = 0, m_sub = 0;
   logic clr_prev = 1'b0;
   logic exp_err = 1'b0;

   // Monitor: compares every cycle away from the active edge
   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_rdy, exp_v;
      logic exp_busy;
      item_t it;
      if (!rst_n) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_flags", rsp_flags, 0);
         check("rst_rsp_data", rsp_data, 0);
         check("rst_cls_valid", {cls_valid, cls_enable}, 0);
         check("rst_busy", busy, 0);
         check("rst_err", err, 0);
         check("rst_stats", {stat_nan_cnt, stat_inf_cnt, stat_sub_cnt}, 0);
         for (int i = 0; i < N; i++) q[i].delete();
         m_pend = '0; taken = '0; m_rr = 0;
         m_nan = 0; m_inf = 0; m_sub = 0; clr_prev = 1'b0;
      end else begin
         exp_busy = |m_pend;
`ifdef FP16_SPECIAL_SCHED_STATS_EN
         if (clr_prev) begin
            m_nan = 0; m_inf = 0; m_sub = 0;
         end else begin
            for (int i = 0; i < N; i++)
               if (q[i].size() != 0 && q[i][0].rdy == cyc) begin
                  if (q[i][0].f[4] && m_nan < (1 << CW) - 1) m_nan++;
                  if ((q[i][0].f[3] || q[i][0].f[2]) && m_inf < (1 << CW) - 1) m_inf++;
                  if (q[i][0].f[0] && m_sub < (1 << CW) - 1) m_sub++;
               end
         end
`endif
         clr_prev = stat_clr;
         check("stat_nan_cnt", stat_nan_cnt, CW'(m_nan));
         check("stat_inf_cnt", stat_inf_cnt, CW'(m_inf));
         check("stat_sub_cnt", stat_sub_cnt, CW'(m_sub));

         // expected grant: first requester at/after the pointer with nothing outstanding
         g = -1;
         if (sched_en)
            for (int k = 0; k < N; k++)
               if (g < 0 && req_valid[(m_rr + k) % N] && !m_pend[(m_rr + k) % N])
                  g = (m_rr + k) % N;
         exp_rdy = (g >= 0) ? N'(1 << g) : '0;
         check("req_ready", req_ready, exp_rdy);
         check("cls_valid", {cls_valid, cls_enable}, (g >= 0) ? 2'b11 : 2'b00);
         taken = exp_rdy;
         if (g >= 0) begin
            check("cls_operand", {cls_sign, cls_exp, cls_mant}, req_data[16*g +: 16]);
            it.f = classify(req_data[16*g +: 16]);
            it.d = req_data[16*g +: 16];
            it.rdy = cyc + 2;
            q[g].push_back(it);
            m_pend[g] = 1'b1;
            m_rr = (g + 1) % N;
         end

         for (int i = 0; i < N; i++)
            exp_v[i] = (q[i].size() != 0) && (cyc >= int'(q[i][0].rdy));
         check("rsp_valid", rsp_valid, exp_v);
         for (int i = 0; i < N; i++)
            if (exp_v[i] && rsp_valid[i] && rsp_ready[i]) begin
               it = q[i].pop_front();
               check("rsp_flags", rsp_flags[5*i +: 5], it.f);
               check("rsp_data", rsp_data[16*i +: 16], it.d);
               m_pend[i] = 1'b0;
            end
         check("busy", busy, exp_busy);
         check("err", err, exp_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand on requester i and return once it has been accepted
   task automatic send(input int i, input logic [15:0] d);
      int k;
      req_valid[i] = 1'b1;
      req_data[16*i +: 16] = d;
      for (k = 0; k < 40; k++) begin
         tick();
         if (taken[i]) break;
      end
      if (k == 40) check("send_timeout", 1, 0);
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      int k;
      req_valid = '0;
      rsp_ready = '1;
      for (k = 0; k < 60 && m_pend != 0; k++) tick();
      if (m_pend != 0) check("drain_timeout", m_pend, 0);
   endtask

   initial begin
      int bp_grants;
      repeat (3) tick();
      rst_n = 1'b1;
      sched_en = 1'b1;
      rsp_ready = '1;

      // single request on requester 2
      send(2, 16'h7C00);
      drain();

      // randomized traffic with random backpressure and scheduler gaps
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (taken[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
               req_valid[i] = 1'b1;
               req_data[16*i +: 16] = rand_op();
            end
         end
         rsp_ready = N'($urandom);
         sched_en = ($urandom_range(0, 7) != 0);
         tick();
      end
      sched_en = 1'b1;
      drain();

      // response backpressure on requester 0
      rsp_ready = 4'b1110;
      bp_grants = 0;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         req_data[16*i +: 16] = (i == 0) ? 16'h0001 : rand_op();
      end
      for (int c = 0; c < 60; c++) begin
         tick();
         if (c == 40) begin
            check("bp_req0_grants", bp_grants, 1);
            rsp_ready = '1;
         end
         if (c < 40 && taken[0]) bp_grants++;
         for (int i = 0; i < N; i++)
            if (taken[i]) req_data[16*i +: 16] = (i == 0) ? 16'h0001 : rand_op();
      end
      drain();

      // scheduler disable in the cycle after an issue
      rsp_ready = '0;
      send(1, 16'h0000);
      sched_en = 1'b0;
      req_valid = '1;
      repeat (5) tick();
      rsp_ready = '1;
      repeat (3) tick();
      check("sched_off_busy", busy, 0);
      req_valid = '0;
      sched_en = 1'b1;
      drain();

      // reset while a result is in flight and slot 0 is full
      rsp_ready = '0;
      send(0, 16'h3C00);
      send(3, 16'h7E00);
      rst_n = 1'b0;
      req_valid = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_rsp_valid", rsp_valid, 0);

      // spurious classifier result with nothing in flight
      rsp_ready = '1;
      spur = 1'b1;
      tick();
      spur = 1'b0;
      exp_err = 1'b1;
      repeat (3) tick();

      // statistics
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      send(1, 16'h7E00);
      send(3, 16'hFC00);
      send(1, 16'h7E00);
      send(3, 16'hFC00);
      send(0, 16'h7E00);
      drain();
      repeat (2) tick();
`ifdef FP16_SPECIAL_SCHED_STATS_EN
      check("stat_nan_3", stat_nan_cnt, 3);
      check("stat_inf_2", stat_inf_cnt, 2);
`else
      check("stat_nan_off", stat_nan_cnt, 0);
      check("stat_inf_off", stat_inf_cnt, 0);
`endif
      send(1, 16'h7E00);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      drain();
      repeat (2) tick();
      check("stat_clr_coincident", stat_nan_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
